// File: rtl/sr_ctrl_latch_pkg.sv
// sr_ctrl_latch_pkg: shared per-bit action enum, default width, decoder.
// Used by sr_ctrl_cell and sr_ctrl_latch.
package sr_ctrl_latch_pkg;

  localparam int SR_WIDTH_DEF = 1;

  typedef enum logic [1:0] {
    HOLD,
    SET,
    CLR,
    CONFLICT
  } sr_act_t;

  function automatic sr_act_t sr_decode(
    input logic en,
    input logic s,
    input logic r
  );
    sr_act_t act;
    act = HOLD;
    unique case (1'b1)
      (!en || (!s && !r)): act = HOLD;
      (en && s && !r):     act = SET;
      (en && !s && r):     act = CLR;
      (en && s && r):      act = CONFLICT;
      default:             act = HOLD;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/sr_ctrl_cell.sv
// sr_ctrl_cell: one clocked SR storage bit with enable.
// Ports: clk, rst (async high), en, s, r -> q (registered), conflict (comb).
module sr_ctrl_cell
  import sr_ctrl_latch_pkg::*;
#(
  parameter logic ILLEGAL_Q = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic conflict
);

  sr_act_t act;

  assign act      = sr_decode(en, s, r);
  assign conflict = (act == CONFLICT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case (act)
        SET:      q <= 1'b1;
        CLR:      q <= 1'b0;
        CONFLICT: q <= ILLEGAL_Q;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sr_ctrl_latch.sv
// sr_ctrl_latch: WIDTH independent clocked SR bits with enable and a
// registered conflict flag. Ports: clk, rst (async high), en, s, r, q, qn,
// illegal; SR_CTRL_LATCH_STICKY_ERR_EN adds err_clr in, err_sticky out.
module sr_ctrl_latch
  import sr_ctrl_latch_pkg::*;
#(
  parameter int   WIDTH     = SR_WIDTH_DEF,
  parameter logic ILLEGAL_Q = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
`ifdef SR_CTRL_LATCH_STICKY_ERR_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic             illegal
);

  logic [WIDTH-1:0] conflict;
  logic             any_conflict;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ctrl_cell #(
      .ILLEGAL_Q (ILLEGAL_Q)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .s        (s[i]),
      .r        (r[i]),
      .q        (q[i]),
      .conflict (conflict[i])
    );
  end

  // Combinational complement keeps qn tracking q through async reset too.
  assign qn           = ~q;
  assign any_conflict = |conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
    end else begin
      illegal <= any_conflict;
    end
  end

`ifdef SR_CTRL_LATCH_STICKY_ERR_EN
  // A new conflict outranks a clear sampled on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (any_conflict) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sr_ctrl_latch.sv
// tb_sr_ctrl_latch: directed self-checking bench for sr_ctrl_latch, WIDTH=4.
// Optional sticky-error checks follow SR_CTRL_LATCH_STICKY_ERR_EN.
module tb_sr_ctrl_latch;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] s   = '0;
  logic [W-1:0] r   = '0;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         illegal;
`ifdef SR_CTRL_LATCH_STICKY_ERR_EN
  logic         err_clr = 1'b0;
  logic         err_sticky;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sr_ctrl_latch #(
    .WIDTH     (W),
    .ILLEGAL_Q (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s          (s),
    .r          (r),
    .q          (q),
    .qn         (qn),
`ifdef SR_CTRL_LATCH_STICKY_ERR_EN
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
`endif
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [W-1:0] sv,
                      input logic [W-1:0] rv);
    @(negedge clk);
    en = e;
    s  = sv;
    r  = rv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qn", 32'(qn), 32'hF);
    chk("rst_ill", 32'(illegal), 32'h0);
`ifdef SR_CTRL_LATCH_STICKY_ERR_EN
    chk("rst_sticky", 32'(err_sticky), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    step(1'b0, 4'hF, 4'h0);
    step(1'b0, 4'hF, 4'h0);
    chk("dis_q", 32'(q), 32'h0);
    chk("dis_qn", 32'(qn), 32'hF);
    chk("dis_ill", 32'(illegal), 32'h0);

    step(1'b1, 4'hF, 4'h0);
    chk("set_q", 32'(q), 32'hF);
    chk("set_qn", 32'(qn), 32'h0);
    step(1'b1, 4'h0, 4'h0);
    chk("hold_q", 32'(q), 32'hF);
    step(1'b1, 4'h0, 4'hF);
    chk("clr_q", 32'(q), 32'h0);

    step(1'b0, 4'hF, 4'h0);
    chk("gate_q", 32'(q), 32'h0);
    step(1'b1, 4'hF, 4'h0);
    chk("ungate_q", 32'(q), 32'hF);

    step(1'b1, 4'hF, 4'hF);
    chk("conf_q", 32'(q), 32'h0);
    chk("conf_qn", 32'(qn), 32'hF);
    chk("conf_ill", 32'(illegal), 32'h1);
    step(1'b1, 4'h0, 4'h0);
    chk("conf_ill_drop", 32'(illegal), 32'h0);

    step(1'b1, 4'b1010, 4'b0011);
    chk("multi_q", 32'(q), 32'h8);
    chk("multi_qn", 32'(qn), 32'h7);
    chk("multi_ill", 32'(illegal), 32'h1);

    step(1'b0, 4'hF, 4'hF);
    chk("dis_conf_q", 32'(q), 32'h8);
    chk("dis_conf_ill", 32'(illegal), 32'h0);

    step(1'b1, 4'h1, 4'h8);
    chk("mix_q", 32'(q), 32'h1);

    step(1'b1, 4'hF, 4'h0);
    chk("pre_async_q", 32'(q), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_q", 32'(q), 32'h0);
    chk("async_qn", 32'(qn), 32'hF);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 4'h4, 4'h4);
    chk("pre_async_ill", 32'(illegal), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_ill", 32'(illegal), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'h2, 4'h0);
    chk("resume_q", 32'(q), 32'h2);

`ifdef SR_CTRL_LATCH_STICKY_ERR_EN
    step(1'b1, 4'h1, 4'h1);
    chk("stk_set", 32'(err_sticky), 32'h1);
    step(1'b1, 4'h0, 4'h0);
    chk("stk_hold", 32'(err_sticky), 32'h1);
    @(negedge clk);
    err_clr = 1'b1;
    step(1'b1, 4'h0, 4'h0);
    chk("stk_clr", 32'(err_sticky), 32'h0);
    step(1'b1, 4'h1, 4'h1);
    chk("stk_set_wins", 32'(err_sticky), 32'h1);
    @(negedge clk);
    err_clr = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("stk_rst", 32'(err_sticky), 32'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sr_ctrl_latch.md
SR_CTRL_LATCH -- requirements
Module: sr_ctrl_latch

Interface
REQ-001 SHALL provide parameter: WIDTH, default 1, number of independent SR storage bits.
REQ-002 SHALL provide parameter: ILLEGAL_Q, default 1'b0, value loaded into a bit when S and R are both high.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-004 SHALL have port: clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: en  input  1  control/enable; s and r are ignored while low.
REQ-007 SHALL have port: s  input  WIDTH  per-bit set request.
REQ-008 SHALL have port: r  input  WIDTH  per-bit reset request.
REQ-009 SHALL have port: q  output  WIDTH  stored state.
REQ-010 SHALL have port: qn  output  WIDTH  bitwise complement of q, always.
REQ-011 SHALL have port: illegal  output  1  registered flag, high for the cycle after any bit was sampled with en=1, s=1, r=1.

Function
REQ-012 SHALL sample en, s and r on each rising clk edge; q updates on that edge, visible one cycle after the inputs are applied.
REQ-013 SHALL hold every bit of q when en=0, regardless of s and r.
REQ-014 SHALL, per bit with en=1: s=0 r=0 -> hold; s=1 r=0 -> q=1; s=0 r=1 -> q=0; s=1 r=1 -> q=ILLEGAL_Q.
REQ-015 SHALL treat each bit independently; a conflict on one bit does not affect other bits.
REQ-016 SHALL drive illegal = OR over bits of (en & s & r), registered; illegal SHALL be 0 in any cycle following a sample with no conflict.
REQ-017 SHALL never produce X on q/qn/illegal after reset, for any 0/1 input combination.
REQ-018 SHALL keep qn exactly equal to ~q at all times, including during reset.

Reset
REQ-019 SHALL, while rst=1, force q=0, qn=all ones, illegal=0 immediately (asynchronous), overriding en/s/r.
REQ-020 SHALL resume normal sampling on the first rising clk edge after rst deasserts; rst asserted mid-operation discards any pending update.

Configuration
REQ-021 SHALL support macro SR_CTRL_LATCH_STICKY_ERR_EN.
REQ-022 With SR_CTRL_LATCH_STICKY_ERR_EN defined, SHALL add ports err_clr (input, 1) and err_sticky (output, 1); err_sticky sets on any cycle illegal would be set, stays high until err_clr=1 is sampled or rst; simultaneous set and err_clr -> set wins.
REQ-023 Without the macro, SHALL omit err_clr/err_sticky and all associated logic; all other behaviour is identical.

Structure
REQ-024 SHALL place in shared package sr_ctrl_latch_pkg: the per-bit action enum (HOLD, SET, CLR, CONFLICT) and the default WIDTH constant.
REQ-025 SHALL implement one bit in sub-module sr_ctrl_cell (inputs clk, rst, en, s, r; outputs q, conflict), instantiated WIDTH times by sr_ctrl_latch.
REQ-026 SHALL compute illegal and the sticky error in sr_ctrl_latch, not in the cell.

Verification
REQ-027 Reset and disabled: rst pulse, then en=0 s=1 r=0 for 2 cycles -> q=0, qn=1, illegal=0.
REQ-028 Set/hold/reset: en=1 s=1 r=0 -> q=1 next cycle; en=1 s=0 r=0 -> q stays 1; en=1 s=0 r=1 -> q=0.
REQ-029 Enable gating: q=0, en=0 s=1 r=0 -> q stays 0; then en=1 s=1 r=0 -> q=1.
REQ-030 Conflict: en=1 s=1 r=1 with ILLEGAL_Q=0 -> q=0, qn=1, illegal=1 for one cycle; next cycle with s=r=0 -> illegal=0.
REQ-031 Multi-bit, WIDTH=4: q=0000, en=1 s=1010 r=0011 -> q=1000 (bit1 conflict -> ILLEGAL_Q=0), illegal=1.
REQ-032 Async reset mid-operation: q=1, assert rst between clk edges -> q=0 before the next edge; with SR_CTRL_LATCH_STICKY_ERR_EN, conflict then err_clr=1 -> err_sticky 1 then 0.
